// File: rtl/mmu_loader.sv
// mmu_loader: host byte-stream writer and sequencer for the 2x2 systolic matrix unit.
// Collects four weight bytes and four input bytes, then runs mmu_feeder for one pass
// of RUN_CYCLES cycles.
// Optional feature: define MMU_LOADER_WEIGHT_REUSE_EN to honour reuse_weights. When
// honoured, a pass or an abort can return to the input phase and keep the loaded weights.
module mmu_loader #(
  parameter int RUN_CYCLES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       abort,
  input  logic       reuse_weights,
  output logic [7:0] weight_0,
  output logic [7:0] weight_1,
  output logic [7:0] weight_2,
  output logic [7:0] weight_3,
  output logic [7:0] input_0,
  output logic [7:0] input_1,
  output logic [7:0] input_2,
  output logic [7:0] input_3,
  output logic       mmu_en,
  output logic [2:0] mmu_cycles,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {LOAD_W, LOAD_X, RUN} state_t;

  localparam logic [2:0] LAST = 3'(RUN_CYCLES - 1);

  state_t     state;
  logic [1:0] idx;
  logic [7:0] w_q [4];
  logic [7:0] x_q [4];
  logic       accept;
  logic       reuse;
  state_t     after_pass;

`ifdef MMU_LOADER_WEIGHT_REUSE_EN
  assign reuse = reuse_weights;
`else
  logic unused_reuse;
  assign unused_reuse = reuse_weights;
  assign reuse        = 1'b0;
`endif

  // Load states are the only ones that take bytes; held low while reset is asserted.
  assign in_ready   = !rst && (state != RUN);
  assign accept     = in_valid && in_ready;
  assign after_pass = reuse ? LOAD_X : LOAD_W;

  assign weight_0 = w_q[0];
  assign weight_1 = w_q[1];
  assign weight_2 = w_q[2];
  assign weight_3 = w_q[3];
  assign input_0  = x_q[0];
  assign input_1  = x_q[1];
  assign input_2  = x_q[2];
  assign input_3  = x_q[3];

  // Load/run sequencer with registered feeder controls and operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD_W;
      idx        <= 2'd0;
      mmu_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mmu_cycles <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        w_q[i] <= 8'd0;
        x_q[i] <= 8'd0;
      end
    end else if (abort) begin
      // Abort overrides any byte offered this cycle; operands are kept.
      state      <= after_pass;
      idx        <= 2'd0;
      mmu_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mmu_cycles <= 3'd0;
    end else begin
      case (state)
        LOAD_W: begin
          if (accept) begin
            w_q[idx] <= in_data;
            idx      <= idx + 2'd1;
            if (idx == 2'd3) state <= LOAD_X;
          end
        end
        LOAD_X: begin
          if (accept) begin
            x_q[idx] <= in_data;
            idx      <= idx + 2'd1;
            if (idx == 2'd3) begin
              state      <= RUN;
              mmu_en     <= 1'b1;
              busy       <= 1'b1;
              mmu_cycles <= 3'd0;
              done       <= (LAST == 3'd0);
            end
          end
        end
        RUN: begin
          if (mmu_cycles == LAST) begin
            state      <= after_pass;
            mmu_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mmu_cycles <= 3'd0;
          end else begin
            mmu_cycles <= mmu_cycles + 3'd1;
            done       <= ((mmu_cycles + 3'd1) == LAST);
          end
        end
        default: state <= LOAD_W;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_loader.sv
// Testbench for mmu_loader (default build: weight reuse disabled).
module tb_mmu_loader;

  localparam int RUN = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready;
  logic       abort = 1'b0;
  logic       reuse_weights = 1'b0;
  logic [7:0] weight_0, weight_1, weight_2, weight_3;
  logic [7:0] input_0, input_1, input_2, input_3;
  logic       mmu_en, busy, done;
  logic [2:0] mmu_cycles;

  int checks = 0;
  int errors = 0;

  // Reference model: how many bytes of the current 8-byte load have been taken,
  // and position within the compute pass (-1 when not computing).
  int         nbytes = 0;
  int         run_pos = -1;
  logic [7:0] mw [4];
  logic [7:0] mx [4];

  mmu_loader #(.RUN_CYCLES(RUN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .abort(abort), .reuse_weights(reuse_weights),
    .weight_0(weight_0), .weight_1(weight_1), .weight_2(weight_2), .weight_3(weight_3),
    .input_0(input_0), .input_1(input_1), .input_2(input_2), .input_3(input_3),
    .mmu_en(mmu_en), .mmu_cycles(mmu_cycles), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check in_ready, advance model and DUT, check outputs.
  task automatic cyc(input bit v, input logic [7:0] d, input bit a, input bit r);
    @(negedge clk);
    in_valid = v; in_data = d; abort = a; rst = r;
    #1;
    chk("in_ready", int'(in_ready), int'(!r && run_pos < 0));
    @(posedge clk);
    if (r) begin
      nbytes = 0; run_pos = -1;
      for (int i = 0; i < 4; i++) begin mw[i] = 8'd0; mx[i] = 8'd0; end
    end else if (a) begin
      nbytes = 0; run_pos = -1;
    end else if (run_pos >= 0) begin
      if (run_pos == RUN - 1) begin run_pos = -1; nbytes = 0; end
      else run_pos++;
    end else if (v) begin
      if (nbytes < 4) mw[nbytes] = d; else mx[nbytes - 4] = d;
      nbytes++;
      if (nbytes == 8) begin nbytes = 0; run_pos = 0; end
    end
    #1;
    chk("mmu_en", int'(mmu_en), int'(run_pos >= 0));
    chk("busy", int'(busy), int'(run_pos >= 0));
    chk("done", int'(done), int'(run_pos == RUN - 1));
    chk("mmu_cycles", int'(mmu_cycles), (run_pos >= 0) ? run_pos : 0);
    chk("weight_0", int'(weight_0), int'(mw[0]));
    chk("weight_1", int'(weight_1), int'(mw[1]));
    chk("weight_2", int'(weight_2), int'(mw[2]));
    chk("weight_3", int'(weight_3), int'(mw[3]));
    chk("input_0", int'(input_0), int'(mx[0]));
    chk("input_1", int'(input_1), int'(mx[1]));
    chk("input_2", int'(input_2), int'(mx[2]));
    chk("input_3", int'(input_3), int'(mx[3]));
  endtask

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         en;
    int         cyc;
    bit         dn;
    bit         rdy;
  } vec_t;

  vec_t tbl [14];

  initial begin
    // Spec timeline: bytes 01..08 back to back, then the 6-cycle pass and return to load.
    for (int i = 0; i < 7; i++) tbl[i] = '{1'b1, 8'(i + 1), 1'b0, 0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 8'h08, 1'b1, 0, 1'b0, 1'b0};
    for (int i = 8; i < 13; i++) tbl[i] = '{1'b0, 8'h00, 1'b1, i - 7, (i == 12), 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1};

    for (int i = 0; i < 4; i++) begin mw[i] = 8'd0; mx[i] = 8'd0; end

    // Reset
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 1);
    chk("reset_mmu_en", int'(mmu_en), 0);
    chk("reset_weight_0", int'(weight_0), 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("ready_after_reset", int'(in_ready), 1);

    // Table-driven first pass
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].v, tbl[i].d, 0, 0);
      chk("tbl_en", int'(mmu_en), int'(tbl[i].en));
      chk("tbl_cycles", int'(mmu_cycles), tbl[i].cyc);
      chk("tbl_done", int'(done), int'(tbl[i].dn));
      chk("tbl_ready", int'(in_ready), int'(tbl[i].rdy));
    end
    chk("tbl_w3", int'(weight_3), 8'h04);
    chk("tbl_x0", int'(input_0), 8'h05);
    chk("tbl_x3", int'(input_3), 8'h08);

    // Host holds 0xAA during RUN; it becomes w0 on the first load cycle.
    for (int i = 0; i < 8; i++) cyc(1, 8'h30 + 8'(i), 0, 0);
    for (int i = 0; i < RUN; i++) begin
      cyc(1, 8'hAA, 0, 0);
      chk("hold_w0", int'(weight_0), 8'h30);
    end
    cyc(1, 8'hAA, 0, 0);
    chk("hold_w0_accepted", int'(weight_0), 8'hAA);
    for (int i = 1; i < 8; i++) cyc(1, 8'(i), 0, 0);
    for (int i = 0; i < RUN; i++) cyc(0, 8'h00, 0, 0);

    // Gapped stream 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      cyc(1, 8'h10 + 8'(i), 0, 0);
      cyc(0, 8'hEE, 0, 0);
    end
    chk("gap_x3", int'(input_3), 8'h17);
    for (int i = 0; i < RUN - 1; i++) cyc(0, 8'h00, 0, 0);
    chk("gap_pass_end", int'(mmu_en), 0);

    // Abort with a byte at LOAD_X index 2
    for (int i = 0; i < 6; i++) cyc(1, 8'h40 + 8'(i), 0, 0);
    cyc(1, 8'h55, 1, 0);
    chk("abort_no_write", int'(input_2), 8'h16);
    for (int i = 0; i < 8; i++) cyc(1, 8'h10 + 8'(i), 0, 0);
    chk("abort_then_run", int'(mmu_en), 1);
    for (int i = 0; i < RUN; i++) cyc(0, 8'h00, 0, 0);

    // Abort at mmu_cycles == 3
    for (int i = 0; i < 8; i++) cyc(1, 8'h60 + 8'(i), 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 0);
    chk("abort_run_at3", int'(mmu_cycles), 3);
    cyc(0, 8'h00, 1, 0);
    chk("abort_run_en", int'(mmu_en), 0);
    chk("abort_run_cycles", int'(mmu_cycles), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'h00, 0, 0);
      chk("abort_run_no_done", int'(done), 0);
    end

    // reuse_weights ignored in default build: bytes land in weights, no RUN
    reuse_weights = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1, 8'h70 + 8'(i), 0, 0);
    for (int i = 0; i < RUN; i++) cyc(0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 8'h21 + 8'(i), 0, 0);
    chk("reuse_w0", int'(weight_0), 8'h21);
    chk("reuse_w3", int'(weight_3), 8'h24);
    chk("reuse_x0_kept", int'(input_0), 8'h74);
    chk("reuse_no_run", int'(mmu_en), 0);
    reuse_weights = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reuse_weights = 1'($urandom_range(0, 1));
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
